// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply and
// restoring divide, one bit per cycle over operand magnitudes, sign fix-up on the final edge.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        hilo_rd,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall_req
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;   // product, or {remainder, dividend/quotient}
    logic [63:0] opa_q, opa_d;   // shifting multiplicand
    logic [31:0] opb_q, opb_d;   // multiplier, or divisor magnitude
    logic        neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [31:0] rsraw_q, rsraw_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic        sgn;
    logic [31:0] ma, mb;
    logic [63:0] prod_nx, prod_fin;
    logic [32:0] r33;
    logic        ge;
    logic [31:0] rem_nx, quo_nx;

    assign sgn = ~op[0];
    assign ma  = (sgn && rs[31]) ? -rs : rs;
    assign mb  = (sgn && rt[31]) ? -rt : rt;

    assign prod_nx  = acc_q + (opb_q[0] ? opa_q : 64'd0);
    assign prod_fin = neg_q ? -prod_nx : prod_nx;

    // Partial remainder stays below the divisor, so the 33-bit trial fits and the
    // difference on success always fits back into 32 bits.
    assign r33    = {acc_q[63:32], acc_q[31]};
    assign ge     = r33 >= {1'b0, opb_q};
    assign rem_nx = ge ? (r33[31:0] - opb_q) : r33[31:0];
    assign quo_nx = {acc_q[30:0], ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        rsraw_d = rsraw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (mthi || mtlo) begin
                    state_d = IDLE;
                end else if (start && !flush) begin
                    state_d = op[1] ? DIV : MUL;
                    cnt_d   = 5'd0;
                    acc_d   = op[1] ? {32'd0, ma} : 64'd0;
                    opa_d   = {32'd0, ma};
                    opb_d   = mb;
                    neg_d   = sgn && (rs[31] ^ rt[31]);
                    rneg_d  = sgn && rs[31];
                    dz_d    = (rt == 32'd0);
                    rsraw_d = rs;
                end
            end
            default: begin
                if (flush || mthi || mtlo) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                    if (state_q == MUL) begin
                        acc_d = prod_nx;
                        opa_d = {opa_q[62:0], 1'b0};
                        opb_d = {1'b0, opb_q[31:1]};
                    end else begin
                        acc_d = {rem_nx, quo_nx};
                    end
                    if (cnt_q == 5'd31) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (state_q == MUL) begin
                            {hi_d, lo_d} = prod_fin;
                        end else if (dz_q) begin
                            lo_d = 32'hFFFF_FFFF;
                            hi_d = rsraw_q;
                        end else begin
                            lo_d = neg_q  ? -quo_nx : quo_nx;
                            hi_d = rneg_q ? -rem_nx : rem_nx;
                        end
                    end
                end
            end
        endcase

        // Explicit HI/LO writes land in every state and win over any result.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opa_q   <= 64'd0;
            opb_q   <= 32'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            rsraw_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            rsraw_q <= rsraw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = (state_q == MUL) || (state_q == DIV);
    assign done      = done_q;
    assign stall_req = busy && (start || hilo_rd || mthi || mtlo);
endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: reset, mult/div results and latency, hazards, flush, abort.
module tb_mdu;
    logic        clk, rst_n, start, mthi, mtlo, hilo_rd, flush;
    logic [1:0]  op;
    logic [31:0] rs, rt, wdata, hi, lo;
    logic        busy, done, stall_req;
    int          n_chk, n_fail;

    mdu dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .hilo_rd(hilo_rd), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, check busy window, result at edge N+32 and the single done pulse.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int busy_bad;
        busy_bad = 0;
        op = o; rs = a; rt = b; start = 1'b1;
        tick();                              // edge N
        start = 1'b0;
        for (int i = 0; i < 31; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
            tick();
        end
        if (busy !== 1'b1) busy_bad++;
        tick();                              // edge N+32
        n_chk++;
        if (busy_bad != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_window: bad=%0d busy_after=%b required 0/0", nm, busy_bad, busy);
        end
        n_chk++;
        if (hi !== ehi || lo !== elo) begin
            n_fail++;
            $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", nm, hi, lo, ehi, elo);
        end
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_pulse: done=%b required 1", nm, done);
        end
        tick();
        n_chk++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: done=%b required 0", nm, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; op = 0; rs = 0; rt = 0; mthi = 0; mtlo = 0;
        wdata = 0; hilo_rd = 0; flush = 0;
        #23;
        n_chk++;
        if ({hi, lo, busy, done, stall_req} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b required all 0",
                     hi, lo, busy, done, stall_req);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        run_op("mult_neg1x2",   2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_ffx2",    2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_neg3xneg4",2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0, 32'd12);
        run_op("multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    endtask

    task automatic test_div();
        run_op("div_neg7by2",   2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100by0",   2'b11, 32'd100, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_neg5by0",   2'b10, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_overflow",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_100by7",   2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_7byneg2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    endtask

    task automatic test_mthi_mtlo();
        mthi = 1'b1; wdata = 32'hCAFE_0001; start = 1'b1; op = 2'b00; rs = 3; rt = 3;
        tick();
        mthi = 1'b0; start = 1'b0;
        n_chk++;
        if (hi !== 32'hCAFE_0001 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_priority: hi=%h busy=%b required hi=cafe0001 busy=0", hi, busy);
        end
        mtlo = 1'b1; wdata = 32'hBEEF_0002;
        tick();
        mtlo = 1'b0;
        n_chk++;
        if (lo !== 32'hBEEF_0002 || hi !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL mtlo_write: hi=%h lo=%h required hi=cafe0001 lo=beef0002", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int stall_bad;
        stall_bad = 0;
        op = 2'b00; rs = 32'd7; rt = 32'd6; start = 1'b1;
        tick();
        start = 1'b0; hilo_rd = 1'b1;
        for (int i = 0; i < 31; i++) begin
            if (stall_req !== 1'b1) stall_bad++;
            if (i == 5) begin
                op = 2'b11; rs = 32'd1000; rt = 32'd3; start = 1'b1;
                #1;
                if (stall_req !== 1'b1) stall_bad++;
            end
            tick();
            start = 1'b0;
        end
        if (stall_req !== 1'b1) stall_bad++;
        tick();
        n_chk++;
        if (stall_bad != 0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hilo_rd: bad=%0d stall_at_done=%b required 0/0", stall_bad, stall_req);
        end
        n_chk++;
        if (hi !== 32'd0 || lo !== 32'd42 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy: hi=%h lo=%h done=%b required 0/2a/1", hi, lo, done);
        end
        hilo_rd = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int done_seen;
        done_seen = 0;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        op = 2'b11; rs = 32'd99; rt = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1; start = 1'b1;
        tick();
        flush = 1'b0; start = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL flush_abort: busy=%b hi=%h lo=%h required 0/12345678/12345678", busy, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
            tick();
        end
        n_chk++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_done: bad_cycles=%0d required 0", done_seen);
        end
    endtask

    task automatic test_mt_abort();
        int bad;
        bad = 0;
        op = 2'b01; rs = 32'd5; rt = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mtlo = 1'b1; wdata = 32'h0BAD_F00D;
        #1;
        n_chk++;
        if (stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mt_stall: stall=%b required 1", stall_req);
        end
        tick();
        mtlo = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || lo !== 32'h0BAD_F00D || hi !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL mt_abort: busy=%b hi=%h lo=%h required 0/12345678/0badf00d", busy, hi, lo);
        end
        for (int i = 0; i < 35; i++) begin
            if (done !== 1'b0) bad++;
            tick();
        end
        n_chk++;
        if (bad != 0 || lo !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL mt_abort_quiet: done_cycles=%0d lo=%h required 0/0badf00d", bad, lo);
        end
    endtask

    task automatic test_reset_mid();
        op = 2'b00; rs = 32'd9; rt = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        hilo_rd = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({hi, lo, busy, done, stall_req} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: hi=%h lo=%h busy=%b done=%b stall=%b required all 0",
                     hi, lo, busy, done, stall_req);
        end
        hilo_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        #2;
        run_op("mult_after_reset", 2'b00, 32'hFFFF_FFF6, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFE2);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_back_to_back();
        test_flush();
        test_mt_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
